// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with an 8-deep first-word-fall-through byte FIFO.
// rxd is double-synchronised. All frame timing is measured from the detected
// start edge: the start bit is checked at mid-bit, and each data bit and the
// stop bit are then sampled one full bit period after the previous sample.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_AW      = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rxd,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [FIFO_AW:0]   count,
  output logic               rx_busy,
  output logic               overrun,
  output logic               frame_err,
  input  logic               clr_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]      HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]      FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic               sync1_q, rx_s_q;
  state_t             state_q, state_d;
  logic [CW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic               push, stop_bad, pop, full, wr_en;
  logic [7:0]         mem [DEPTH];

  // Receive FSM next-state: counter, bit index, shift register, push/error strobes.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold here through a break so it is reported only once.
        clk_cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping and sticky error flags (a set beats clr_err in the same cycle).
  always_comb begin
    pop      = rd_en && (count_q != '0);
    full     = (count_q == FULL_CNT);
    // A pop in the same cycle frees the slot the push needs.
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + (FIFO_AW + 1)'(1);
    else if (!wr_en && pop) count_d = count_q - (FIFO_AW + 1)'(1);
    overrun_d   = (push && full && !pop) ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    frame_err_d = stop_bad ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
  end

  // State registers; synchroniser resets high so reset release is not a start edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rxd;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // FIFO storage; the completed byte is written on the stop-sample edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= shift_q;
  end

  assign rd_valid  = (count_q != '0);
  assign rd_data   = rd_valid ? mem[rd_ptr_q] : 8'h00;
  assign count     = count_q;
  assign rx_busy   = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
